// File: rtl/result_drain_pkg.sv
// Shared parameters and state encoding for the result drain block.
package result_drain_pkg;

  localparam int WIDTH  = 8;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = $clog2(DEPTH);
  // Checksum is a plain mod-2^WIDTH byte sum, so it shares the data width.
  localparam int CSUM_W = WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    CSUM = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/result_drain_if.sv
// Result write port plus the outgoing valid/ready stream of the result drain.
interface result_drain_if;
  import result_drain_pkg::*;

  logic              WEB;
  logic [ADDR_W-1:0] AddrB;
  logic [WIDTH-1:0]  DataInB;
  logic              Start;
  logic [WIDTH-1:0]  OutData;
  logic              OutValid;
  logic              OutReady;
  logic              OutLast;
  logic              Busy;
  logic              Done;
  logic              Overrun;

  // Producer of results and consumer of the stream.
  modport master (
    output WEB, AddrB, DataInB, Start, OutReady,
    input  OutData, OutValid, OutLast, Busy, Done, Overrun
  );

  // The drain block itself.
  modport slave (
    input  WEB, AddrB, DataInB, Start, OutReady,
    output OutData, OutValid, OutLast, Busy, Done, Overrun
  );

endinterface

// File: rtl/result_buffer.sv
// DEPTH x WIDTH result register file with per-entry valid bits.
// o_full already accounts for a write landing this cycle, so the drain can
// start on the same edge that fills the last entry.
module result_buffer
  import result_drain_pkg::*;
(
  input  logic              clock,
  input  logic              Reset,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]  i_wr_data,
  input  logic              i_clr,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [WIDTH-1:0]  o_rd_data,
  output logic              o_full
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0] w_wr_mask;

  // One-hot of the entry being written this cycle (zero when idle).
  always_comb begin
    w_wr_mask = '0;
    if (i_we) w_wr_mask = DEPTH'(1) << i_wr_addr;
  end

  // Storage needs no reset; contents only matter once marked valid.
  always_ff @(posedge clock) begin
    if (i_we) r_mem[i_wr_addr] <= i_wr_data;
  end

  // Valid bits: set by writes (rewrite is idempotent), cleared after a drain.
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset)     r_valid <= '0;
    else if (i_clr) r_valid <= '0;
    else            r_valid <= r_valid | w_wr_mask;
  end

  assign o_rd_data = r_mem[i_rd_addr];
  assign o_full    = &(r_valid | w_wr_mask);

endmodule

// File: rtl/result_drain.sv
// Captures DEPTH results, then on request streams them in address order
// followed by a mod-256 checksum beat flagged last.
//
//  state | meaning
//  IDLE  | accepting writes, waiting for armed + full buffer
//  SEND  | streaming buf[rd_ptr] until the last entry is accepted
//  CSUM  | presenting the checksum beat with OutLast
//  DONE  | one-cycle Done pulse, buffer/armed/checksum cleared
//
// All stream outputs decode from registered state and datapath, so OutReady
// never reaches OutValid/OutData combinationally.
module result_drain
  import result_drain_pkg::*;
(
  input  logic         clock,
  input  logic         Reset,
  result_drain_if.slave bus
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ADDR_W-1:0]  r_rd_ptr;
  logic [CSUM_W-1:0]  r_csum;
  logic               r_armed;
  logic               r_overrun;

  logic               w_idle;
  logic               w_valid;
  logic               w_xfer;
  logic               w_wr_en;
  logic               w_full;
  logic               w_clr;
  logic [WIDTH-1:0]   w_rd_data;

  assign w_idle  = (r_state == IDLE);
  assign w_valid = (r_state == SEND) || (r_state == CSUM);
  assign w_xfer  = w_valid && bus.OutReady;
  assign w_wr_en = bus.WEB && w_idle;
  assign w_clr   = (r_state == DONE);

  result_buffer u_buf (
    .clock     (clock),
    .Reset     (Reset),
    .i_we      (w_wr_en),
    .i_wr_addr (bus.AddrB),
    .i_wr_data (bus.DataInB),
    .i_clr     (w_clr),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_rd_data),
    .o_full    (w_full)
  );

  // State register.
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; a Start in this cycle counts as armed.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if ((r_armed || bus.Start) && w_full) w_state_nxt = SEND;
      SEND: if (w_xfer && (r_rd_ptr == ADDR_W'(DEPTH - 1))) w_state_nxt = CSUM;
      CSUM: if (w_xfer) w_state_nxt = DONE;
      DONE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Read pointer and running checksum; the pointer wraps to 0 after the last entry.
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      r_rd_ptr <= '0;
      r_csum   <= '0;
    end else if (r_state == SEND && w_xfer) begin
      r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      r_csum   <= r_csum + w_rd_data;
    end else if (w_clr) begin
      r_rd_ptr <= '0;
      r_csum   <= '0;
    end
  end

  // Arm on Start while idle; the request is consumed when the drain finishes.
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset)                r_armed <= 1'b0;
    else if (w_clr)            r_armed <= 1'b0;
    else if (w_idle && bus.Start) r_armed <= 1'b1;
  end

  // Sticky flag for writes dropped while a drain is in flight.
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset)                   r_overrun <= 1'b0;
    else if (bus.WEB && !w_idle)  r_overrun <= 1'b1;
    else if (w_idle && bus.Start) r_overrun <= 1'b0;
  end

  // Stream output decode.
  always_comb begin
    bus.OutData = '0;
    if (r_state == SEND)      bus.OutData = w_rd_data;
    else if (r_state == CSUM) bus.OutData = r_csum;
  end

  assign bus.OutValid = w_valid;
  assign bus.OutLast  = (r_state == CSUM);
  assign bus.Busy     = w_valid;
  assign bus.Done     = (r_state == DONE);
  assign bus.Overrun  = r_overrun;

endmodule
